// File: rtl/processador_completo_pkg.sv
// Shared definitions for the single-cycle RV32I-subset core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package processador_completo_pkg;

  // Major opcodes of the supported instruction subset
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  // funct3 codes used by the decoder
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_PASS_B
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4
  } wb_sel_e;

endpackage

// File: rtl/banco_de_registradores.sv
// 32x32 register file: 2 combinational read ports, 1 synchronous write port.
// Latency: reads same cycle, write visible after the clock edge (read-during-write returns old value).
// Backpressure: none; a write is accepted every cycle that we_i is high.
// Ports: clk_i clock, rst_ni async active-low clear of all registers,
//        rs1/rs2_addr_i read addresses, rs1/rs2_dat_o read data,
//        we_i/rd_addr_i/rd_dat_i write port.
module banco_de_registradores (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_dat_o,
  output logic [31:0] rs2_dat_o,
  input  logic        we_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_dat_i
);

  logic [31:0] registradores [0:31];

  // x0 is never written, so its storage stays at the reset value of 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        registradores[i] <= '0;
      end
    end else if (we_i && (rd_addr_i != 5'd0)) begin
      registradores[rd_addr_i] <= rd_dat_i;
    end
  end

  // Reads come straight from storage, so a same-cycle write is not bypassed.
  assign rs1_dat_o = (rs1_addr_i == 5'd0) ? 32'd0 : registradores[rs1_addr_i];
  assign rs2_dat_o = (rs2_addr_i == 5'd0) ? 32'd0 : registradores[rs2_addr_i];

endmodule

// File: rtl/processador_completo.sv
// Single-cycle RV32I-subset CPU with internal instruction ROM, data RAM and register file.
// Latency: one instruction retired per rising clock edge (CPI=1), no pipeline.
// Backpressure: none; the core never stalls.
// Ports: clk system clock, rst async active-low reset (pc <= RESET_PC, registers cleared).
// PROGRAM selects the ROM image: 0 = self-check program, 1 = load/store/ALU/BNE exercise.
module processador_completo
  import processador_completo_pkg::*;
#(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          PROGRAM    = 0
) (
  input logic clk,
  input logic rst
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  // ---------------------------------------------------------------------
  // Fetch
  // ---------------------------------------------------------------------
  logic [31:0]   pc_q;
  logic [31:0]   pc_d;
  logic [31:0]   pc_plus4;
  logic [31:0]   instr;
  logic [IW-1:0] imem_idx;

  // Word index wraps naturally by dropping the upper pc bits.
  assign imem_idx = pc_q[IW+1:2];

  always_comb begin
    instr = NOP_INSTR;
    if (PROGRAM == 0) begin
      case (int'(imem_idx))
        0:       instr = 32'h0070_0093; // addi x1,x0,7
        1:       instr = 32'h0010_8133; // add  x2,x1,x1
        2:       instr = 32'h4011_01B3; // sub  x3,x2,x1
        3:       instr = 32'h0011_8463; // beq  x3,x1,+8
        4:       instr = 32'h0630_0213; // addi x4,x0,99 (must be skipped)
        5:       instr = 32'h0000_006F; // jal  x0,0 (halt)
        default: instr = NOP_INSTR;
      endcase
    end else begin
      case (int'(imem_idx))
        0:       instr = 32'h0070_0093; // addi x1,x0,7
        1:       instr = 32'h0050_0013; // addi x0,x0,5 (discarded)
        2:       instr = 32'h0010_8133; // add  x2,x1,x1
        3:       instr = 32'h0010_2023; // sw   x1,0(x0)
        4:       instr = 32'h8000_0337; // lui  x6,0x80000
        5:       instr = 32'h0013_23B3; // slt  x7,x6,x1
        6:       instr = 32'h0011_4433; // xor  x8,x2,x1
        7:       instr = 32'h0011_74B3; // and  x9,x2,x1
        8:       instr = 32'h0011_6533; // or   x10,x2,x1
        9:       instr = 32'hFFF0_0593; // addi x11,x0,-1
        10:      instr = 32'h0000_2283; // lw   x5,0(x0)
        11:      instr = 32'hFE20_9EE3; // bne  x1,x2,-4 (loops back to the lw)
        default: instr = NOP_INSTR;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Field extraction and immediates
  // ---------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [4:0]  rd_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [2:0]  funct3;
  logic        f7_alt;
  logic        r_f7_ok;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;

  assign opcode   = instr[6:0];
  assign rd_addr  = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign f7_alt   = instr[30];
  // Only funct7 = 0000000 / 0100000 are base-ISA R-type encodings.
  assign r_f7_ok  = (instr[31] == 1'b0) && (instr[29:25] == 5'd0);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  logic [31:0] rs1_dat;
  logic [31:0] rs2_dat;
  logic [31:0] rd_dat;
  logic        reg_we;

  banco_de_registradores banco_de_registradores (
    .clk_i      (clk),
    .rst_ni     (rst),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_dat_o  (rs1_dat),
    .rs2_dat_o  (rs2_dat),
    .we_i       (reg_we),
    .rd_addr_i  (rd_addr),
    .rd_dat_i   (rd_dat)
  );

  // ---------------------------------------------------------------------
  // Decoder: anything not recognised falls through with all enables low,
  // which makes it behave as a NOP.
  // ---------------------------------------------------------------------
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic [31:0] alu_b;
  logic        mem_we;
  logic        is_jal;
  logic        br_taken;
  logic        rs_eq;

  assign rs_eq = (rs1_dat == rs2_dat);

  always_comb begin
    alu_op   = ALU_ADD;
    alu_b    = rs2_dat;
    wb_sel   = WB_ALU;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    is_jal   = 1'b0;
    br_taken = 1'b0;
    case (opcode)
      OP_R: begin
        if (r_f7_ok) begin
          reg_we = 1'b1;
          case (funct3)
            F3_ADD_SUB: alu_op = f7_alt ? ALU_SUB : ALU_ADD;
            F3_AND:     alu_op = ALU_AND;
            F3_OR:      alu_op = ALU_OR;
            F3_XOR:     alu_op = ALU_XOR;
            F3_SLT:     alu_op = ALU_SLT;
            default:    reg_we = 1'b0;
          endcase
          // Only ADD/SUB may carry the alternate funct7 bit.
          if (f7_alt && (funct3 != F3_ADD_SUB)) begin
            reg_we = 1'b0;
          end
        end
      end
      OP_I: begin
        if (funct3 == F3_ADD_SUB) begin
          reg_we = 1'b1;
          alu_b  = imm_i;
        end
      end
      OP_LW: begin
        if (funct3 == F3_WORD) begin
          reg_we = 1'b1;
          alu_b  = imm_i;
          wb_sel = WB_MEM;
        end
      end
      OP_SW: begin
        if (funct3 == F3_WORD) begin
          mem_we = 1'b1;
          alu_b  = imm_s;
        end
      end
      OP_BR: begin
        case (funct3)
          F3_BEQ:  br_taken = rs_eq;
          F3_BNE:  br_taken = !rs_eq;
          default: br_taken = 1'b0;
        endcase
      end
      OP_JAL: begin
        reg_we = 1'b1;
        wb_sel = WB_PC4;
        is_jal = 1'b1;
      end
      OP_LUI: begin
        reg_we = 1'b1;
        alu_op = ALU_PASS_B;
        alu_b  = imm_u;
      end
      default: begin
        reg_we = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------
  logic [31:0] alu_y;

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD:    alu_y = rs1_dat + alu_b;
      ALU_SUB:    alu_y = rs1_dat - alu_b;
      ALU_AND:    alu_y = rs1_dat & alu_b;
      ALU_OR:     alu_y = rs1_dat | alu_b;
      ALU_XOR:    alu_y = rs1_dat ^ alu_b;
      ALU_SLT:    alu_y = {31'd0, $signed(rs1_dat) < $signed(alu_b)};
      ALU_PASS_B: alu_y = alu_b;
      default:    alu_y = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Data RAM: combinational read, write on the clock edge, not reset.
  // The pc is pinned to RESET_PC while in reset and neither ROM image holds
  // a store there, so no store can land while rst is low.
  // ---------------------------------------------------------------------
  logic [31:0]   dmem [DMEM_WORDS];
  logic [DW-1:0] dmem_idx;
  logic [31:0]   dmem_rdat;

  assign dmem_idx  = alu_y[DW+1:2];
  assign dmem_rdat = dmem[dmem_idx];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      dmem[dmem_idx] <= rs2_dat;
    end
  end

  // ---------------------------------------------------------------------
  // Write-back and next pc
  // ---------------------------------------------------------------------
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    rd_dat = alu_y;
    case (wb_sel)
      WB_MEM:  rd_dat = dmem_rdat;
      WB_PC4:  rd_dat = pc_plus4;
      default: rd_dat = alu_y;
    endcase
  end

  always_comb begin
    pc_d = pc_plus4;
    if (is_jal) begin
      pc_d = pc_q + imm_j;
    end else if (br_taken) begin
      pc_d = pc_q + imm_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_processador_completo.sv
// Self-checking bench: two core instances (self-check ROM and exercise ROM)
// compared every cycle against an instruction-level reference model, with
// fixed directed checks plus randomly timed asynchronous reset episodes.
module tb_processador_completo;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  processador_completo #(.PROGRAM(0)) dut   (.clk(clk), .rst(rst));
  processador_completo #(.PROGRAM(1)) dut_v (.clk(clk), .rst(rst));

  // ---------------------------------------------------------------------
  // Reference model: programs held as decoded instruction records
  // ---------------------------------------------------------------------
  typedef enum int {K_NOP, K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLT, K_ADDI,
                    K_LUI, K_LW, K_SW, K_BEQ, K_BNE, K_JAL} kind_e;

  typedef struct {
    kind_e       k;
    int          rd;
    int          rs1;
    int          rs2;
    logic [31:0] imm;
  } ins_t;

  ins_t        prog  [2][64];
  logic [31:0] m_pc  [2];
  logic [31:0] m_reg [2][32];
  logic [31:0] m_mem [2][64];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_ins(input int p, input int idx, input kind_e k, input int rd,
                         input int rs1, input int rs2, input logic [31:0] imm);
    prog[p][idx].k   = k;
    prog[p][idx].rd  = rd;
    prog[p][idx].rs1 = rs1;
    prog[p][idx].rs2 = rs2;
    prog[p][idx].imm = imm;
  endtask

  task automatic init_programs();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 64; i++)
        set_ins(p, i, K_NOP, 0, 0, 0, 32'd0);
    // self-check program
    set_ins(0, 0, K_ADDI, 1, 0, 0, 32'd7);
    set_ins(0, 1, K_ADD,  2, 1, 1, 32'd0);
    set_ins(0, 2, K_SUB,  3, 2, 1, 32'd0);
    set_ins(0, 3, K_BEQ,  0, 3, 1, 32'd8);
    set_ins(0, 4, K_ADDI, 4, 0, 0, 32'd99);
    set_ins(0, 5, K_JAL,  0, 0, 0, 32'd0);
    // exercise program
    set_ins(1, 0,  K_ADDI, 1,  0, 0, 32'd7);
    set_ins(1, 1,  K_ADDI, 0,  0, 0, 32'd5);
    set_ins(1, 2,  K_ADD,  2,  1, 1, 32'd0);
    set_ins(1, 3,  K_SW,   0,  0, 1, 32'd0);
    set_ins(1, 4,  K_LUI,  6,  0, 0, 32'h8000_0000);
    set_ins(1, 5,  K_SLT,  7,  6, 1, 32'd0);
    set_ins(1, 6,  K_XOR,  8,  2, 1, 32'd0);
    set_ins(1, 7,  K_AND,  9,  2, 1, 32'd0);
    set_ins(1, 8,  K_OR,   10, 2, 1, 32'd0);
    set_ins(1, 9,  K_ADDI, 11, 0, 0, 32'hFFFF_FFFF);
    set_ins(1, 10, K_LW,   5,  0, 0, 32'd0);
    set_ins(1, 11, K_BNE,  0,  1, 2, 32'hFFFF_FFFC);
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pc[p] = 32'd0;
      for (int i = 0; i < 32; i++) m_reg[p][i] = 32'd0;
    end
  endtask

  task automatic model_step(input int p);
    ins_t        in;
    logic [31:0] a, b, res, npc, addr;
    bit          wr;
    in   = prog[p][int'((m_pc[p] >> 2) % 64)];
    a    = m_reg[p][in.rs1];
    b    = m_reg[p][in.rs2];
    npc  = m_pc[p] + 32'd4;
    res  = 32'd0;
    wr   = 1'b0;
    addr = a + in.imm;
    case (in.k)
      K_ADD:  begin res = a + b; wr = 1; end
      K_SUB:  begin res = a - b; wr = 1; end
      K_AND:  begin res = a & b; wr = 1; end
      K_OR:   begin res = a | b; wr = 1; end
      K_XOR:  begin res = a ^ b; wr = 1; end
      K_SLT:  begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wr = 1; end
      K_ADDI: begin res = a + in.imm; wr = 1; end
      K_LUI:  begin res = in.imm; wr = 1; end
      K_LW:   begin res = m_mem[p][int'((addr >> 2) % 64)]; wr = 1; end
      K_SW:   m_mem[p][int'((addr >> 2) % 64)] = b;
      K_BEQ:  if (a == b) npc = m_pc[p] + in.imm;
      K_BNE:  if (a != b) npc = m_pc[p] + in.imm;
      K_JAL:  begin res = m_pc[p] + 32'd4; wr = 1; npc = m_pc[p] + in.imm; end
      default: ;
    endcase
    if (wr && in.rd != 0) m_reg[p][in.rd] = res;
    m_pc[p] = npc;
  endtask

  // ---------------------------------------------------------------------
  // DUT observation
  // ---------------------------------------------------------------------
  function automatic logic [31:0] dut_pc(input int p);
    return (p == 0) ? dut.pc_q : dut_v.pc_q;
  endfunction

  function automatic logic [31:0] dut_reg(input int p, input int i);
    if (p == 0) return dut.banco_de_registradores.registradores[i];
    return dut_v.banco_de_registradores.registradores[i];
  endfunction

  task automatic compare_all(input string tag);
    for (int p = 0; p < 2; p++) begin
      check_val($sformatf("%s p%0d pc", tag, p), dut_pc(p), m_pc[p]);
      for (int i = 0; i < 32; i++)
        check_val($sformatf("%s p%0d x%0d", tag, p, i), dut_reg(p, i), m_reg[p][i]);
    end
  endtask

  // One clock edge; outputs sampled 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) begin
      model_step(0);
      model_step(1);
    end
    #1;
    compare_all(tag);
  endtask

  // Called right after a tick (posedge+1); asserts rst between edges.
  task automatic async_reset(input int d);
    #(d);
    rst = 1'b0;
    model_reset();
    #1;
    compare_all("async_rst");
    check_val("async_rst pc0", dut.pc_q, 32'd0);
    check_val("async_rst x1", dut_reg(0, 1), 32'd0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_final0(input string tag);
    check_val({tag, " x1"}, dut_reg(0, 1), 32'd7);
    check_val({tag, " x2"}, dut_reg(0, 2), 32'd14);
    check_val({tag, " x3"}, dut_reg(0, 3), 32'd7);
    check_val({tag, " x4"}, dut_reg(0, 4), 32'd0);
    check_val({tag, " pc"}, dut.pc_q, 32'd20);
    check_val({tag, " x0"}, dut_reg(0, 0), 32'd0);
    for (int i = 5; i < 32; i++)
      check_val($sformatf("%s x%0d", tag, i), dut_reg(0, i), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    init_programs();
    model_reset();

    // Reset held for two clocks: everything must stay cleared.
    #2 rst = 1'b0;
    #1;
    compare_all("reset");
    check_val("reset pc", dut.pc_q, 32'd0);
    repeat (2) begin
      tick("reset_hold");
      check_val("reset_hold pc", dut.pc_q, 32'd0);
    end

    // Release and run the fixed programs.
    release_rst();
    for (int c = 1; c <= 12; c++) begin
      tick("run");
      if (c <= 10) check_val($sformatf("trace c%0d", c), dut.pc_q, (c <= 3) ? 32'(4 * c) : 32'd20);
      check_val("pc_not_16", {31'd0, dut.pc_q == 32'd16}, 32'd0);
      if (c == 10) check_final0("final");
      if (c == 12) begin
        check_val("v x0",   dut_reg(1, 0),  32'd0);
        check_val("v x5",   dut_reg(1, 5),  32'd7);
        check_val("v x6",   dut_reg(1, 6),  32'h8000_0000);
        check_val("v x7",   dut_reg(1, 7),  32'd1);
        check_val("v x8",   dut_reg(1, 8),  32'd9);
        check_val("v x9",   dut_reg(1, 9),  32'd6);
        check_val("v x10",  dut_reg(1, 10), 32'd15);
        check_val("v x11",  dut_reg(1, 11), 32'hFFFF_FFFF);
        check_val("v mem0", dut_v.dmem[0],  32'd7);
        check_val("v loop pc", dut_v.pc_q,  32'd40);
      end
    end

    // Asynchronous reset at cycle 3, then rerun to the same final state.
    async_reset(2);
    tick("rst_edge");
    release_rst();
    repeat (3) tick("pre_mid");
    check_val("mid pc", dut.pc_q, 32'd12);
    async_reset(2);
    release_rst();
    repeat (10) tick("rerun");
    check_final0("rerun");

    // Random run lengths and reset timing.
    repeat (20) begin
      int n, k, d;
      n = $urandom_range(1, 25);
      k = $urandom_range(0, 2);
      d = $urandom_range(1, 2);
      repeat (n) tick("rand_run");
      async_reset(d);
      repeat (k) tick("rand_hold");
      release_rst();
    end
    repeat (12) tick("tail");
    check_final0("tail");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
